wave_diff_lag: RTL
==================

Name: wave_diff_lag

Overview:
Parametrised multi-channel lagged differentiator for sampled wave data in the AI-match capture path. Accepts a TDM-interleaved sample stream and emits y = ±(x[n] − x[n−L]) per channel. L is runtime-selectable, gain is fixed at build time, results saturate, and output is offset-binary or two's-complement.
Sits between the ADC sample formatter and the period/feature extraction stage.

Parameters:
W, 8, sample and result width in bits (unsigned input)
CHANNELS, 2, number of interleaved channels (≥1)
CH_W, 1, channel index width; must satisfy 2^CH_W ≥ CHANNELS
LAG_MAX, 8, deepest history per channel (≥1)
LAG_W, 4, width of lag input; must satisfy 2^LAG_W > LAG_MAX
NEGATE, 1, 1: y = x[n−L] − x[n]; 0: y = x[n] − x[n−L]
GAIN_SHL, 0, left shift applied to the difference before saturation

Ports:
clk_50M  in  1  system clock
rst  in  1  asynchronous, active-high reset
clear  in  1  synchronous flush of all history, fill counters and out_cnt
lag  in  LAG_W  lag L; 0 is treated as 1; values > LAG_MAX are clamped to LAG_MAX
offset_mode  in  1  1: out_data = y + 2^(W−1); 0: two's complement
in_valid  in  1  sample strobe
in_ch  in  CH_W  channel of in_data
in_data  in  W  unsigned sample
out_valid  out  1  one-cycle result strobe
out_ch  out  CH_W  channel of out_data
out_data  out  W  result
out_sat  out  1  result was clamped (qualified by out_valid)
err_ch  out  1  one-cycle pulse: in_valid with in_ch ≥ CHANNELS
out_cnt  out  16  count of out_valid pulses, wraps at 2^16

Behaviour:
- Reset (async assert, sync release): all outputs 0; history, write pointers and fill counters all 0.
- No backpressure. in_valid may be asserted on every cycle.
- Latency: out_* are registered one cycle after the accepting in_valid edge.
- Per-channel state:
  - ring buffer of LAG_MAX W-bit entries
  - write pointer, wraps LAG_MAX−1 → 0
  - fill counter, saturates at LAG_MAX
- On an accepted sample (in_valid, in_ch < CHANNELS, no clear):
  - read x[n−L] at index (wr_ptr − L) mod LAG_MAX, using pre-write contents;
  - write in_data at wr_ptr; advance wr_ptr; increment fill.
- Warm-up: output is produced only when fill ≥ L before the increment. With L=1, the first sample of each channel yields no out_valid. History is still written during warm-up.
- Arithmetic:
  - d is a signed (W+1)-bit difference, per NEGATE;
  - s = d << GAIN_SHL, held at full width;
  - clamp s to [−2^(W−1), 2^(W−1)−1]; out_sat = 1 iff clamped;
  - offset_mode adds 2^(W−1) modulo 2^W, i.e. inverts the MSB.
- Lag change mid-stream: history is retained and the new L applies from the next sample. The warm-up test uses the current L.
- lag and offset_mode are sampled on the accepting edge.
- clear takes priority over in_valid in the same cycle: the sample is dropped, out_valid = 0, and all channels restart warm-up. err_ch is not raised.
- Invalid channel (in_ch ≥ CHANNELS): err_ch pulses, no state changes, no output.
- Channels are fully independent; interleaving order is arbitrary.
- out_cnt increments on each out_valid and wraps 0xFFFF → 0.

Decomposition:
- Package wave_diff_pkg holds:
  - mode constants OUT_OFFSET / OUT_TWOS;
  - the saturating clamp function (signed input, W-bit result plus sat flag);
  - lag-normalisation function (0 → 1, > LAG_MAX → LAG_MAX).
- Sub-module wave_hist_ring: per-channel ring buffer plus pointer and fill counters.
  - Inputs: write strobe/channel/data, read channel and lag, clear.
  - Outputs: combinational x[n−L] and the "fill ≥ L" flag.
- The top level holds the arithmetic, clamp and output registers.

Test Plan:
- W=8, CH=1, L=1, NEGATE=1, offset mode; samples 100, 90, 95 → no output for the first; then out_data 138, 123; out_sat=0; out_cnt=2.
- L=1, NEGATE=1, offset; samples 0, 255 → d=−255, clamped −128, out_data 0x00, out_sat=1. With NEGATE=0, two's complement → 0x7F, out_sat=1.
- CH=2, L=4, interleaved ch0 = 10,20,…,60 and ch1 = 200,190,…,150, NEGATE=0, two's complement:
  - first output per channel on its 5th sample;
  - ch0 results 40, 40; ch1 results −40 (0xD8), twice;
  - out_ch matches the input channel.
- GAIN_SHL=2, L=1, NEGATE=0, two's complement; samples 50, 70 → 80 (0x50), no sat; samples 70, 110 → 160 clamped to 127, out_sat=1.
- clear asserted together with in_valid mid-stream → that sample is dropped; next sample gives no output; the one after resumes correctly.
- in_ch=3 with CHANNELS=2 → err_ch pulse, no out_valid, channel state unchanged. rst asserted mid-stream → all outputs 0 immediately, warm-up restarts.

Source files
------------

// File: rtl/wave_diff_pkg.sv
// Shared constants and helpers for the lagged wave differentiator.
package wave_diff_pkg;

    // Output coding selected by offset_mode.
    localparam logic OUT_OFFSET = 1'b1;
    localparam logic OUT_TWOS   = 1'b0;

    // Clamp result: low bits of val carry the saturated value, sat marks a clamp.
    typedef struct packed {
        logic        sat;
        logic [63:0] val;
    } clamp_t;

    // Saturate a signed value into the signed range of a w-bit word.
    function automatic clamp_t sat_clamp(input logic signed [63:0] s, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        clamp_t             r;
        hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (w - 1));
        r.sat = 1'b0;
        r.val = s;
        if (s > hi) begin
            r.sat = 1'b1;
            r.val = hi;
        end else if (s < lo) begin
            r.sat = 1'b1;
            r.val = lo;
        end
        return r;
    endfunction

    // A lag of 0 means 1; anything deeper than the history is pinned to it.
    function automatic int norm_lag(input int lag, input int lag_max);
        if (lag < 1) return 1;
        if (lag > lag_max) return lag_max;
        return lag;
    endfunction

endpackage

// File: rtl/wave_hist_ring.sv
// Per-channel sample history: ring buffer, write pointer and fill counter.
// The read side is combinational and sees the contents before this cycle's write.
module wave_hist_ring #(
    parameter int W        = 8,
    parameter int CHANNELS = 2,
    parameter int CH_W     = 1,
    parameter int LAG_MAX  = 8,
    parameter int LAG_W    = 4
) (
    input  logic             clk_50M,
    input  logic             rst,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [W-1:0]     wr_data,
    input  logic [CH_W-1:0]  rd_ch,
    input  logic [LAG_W-1:0] rd_lag,
    output logic [W-1:0]     rd_data,
    output logic             rd_ready
);

    localparam int PTR_W = (LAG_MAX > 1) ? $clog2(LAG_MAX) : 1;
    // Wide enough to hold wr_ptr + LAG_MAX before the modulo fold.
    localparam int AW    = LAG_W + 1;

    logic [W-1:0]     mem    [CHANNELS][LAG_MAX];
    logic [PTR_W-1:0] wr_ptr [CHANNELS];
    logic [LAG_W-1:0] fill   [CHANNELS];
    logic [AW-1:0]    rd_idx;

    // Read x[n-L] at (wr_ptr - L) mod LAG_MAX and report whether L samples exist.
    // rd_lag is expected already normalised to 1..LAG_MAX, so one fold suffices.
    always_comb begin
        rd_data  = '0;
        rd_ready = 1'b0;
        rd_idx   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (rd_ch == CH_W'(c)) begin
                rd_idx = AW'(wr_ptr[c]) + AW'(LAG_MAX) - AW'(rd_lag);
                if (rd_idx >= AW'(LAG_MAX)) begin
                    rd_idx = rd_idx - AW'(LAG_MAX);
                end
                for (int k = 0; k < LAG_MAX; k++) begin
                    if (rd_idx == AW'(k)) begin
                        rd_data = mem[c][k];
                    end
                end
                rd_ready = (fill[c] >= rd_lag);
            end
        end
    end

    // Store accepted samples, advance the pointer and saturate the fill count.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr[c] <= '0;
                fill[c]   <= '0;
                for (int k = 0; k < LAG_MAX; k++) begin
                    mem[c][k] <= '0;
                end
            end
        end else if (clear) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr[c] <= '0;
                fill[c]   <= '0;
                for (int k = 0; k < LAG_MAX; k++) begin
                    mem[c][k] <= '0;
                end
            end
        end else if (wr_en) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_ch == CH_W'(c)) begin
                    for (int k = 0; k < LAG_MAX; k++) begin
                        if (wr_ptr[c] == PTR_W'(k)) begin
                            mem[c][k] <= wr_data;
                        end
                    end
                    if (wr_ptr[c] == PTR_W'(LAG_MAX - 1)) begin
                        wr_ptr[c] <= '0;
                    end else begin
                        wr_ptr[c] <= wr_ptr[c] + 1'b1;
                    end
                    if (fill[c] != LAG_W'(LAG_MAX)) begin
                        fill[c] <= fill[c] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/wave_diff_lag.sv
// Multi-channel lagged differentiator: y = +/-(x[n] - x[n-L]), scaled,
// saturated and coded as two's complement or offset binary.
//
// Stream protocol: there is no ready. A sample is taken on every clock edge
// where in_valid is high; it is accepted when in_ch < CHANNELS and clear is
// low. An accepted sample past warm-up produces exactly one out_valid pulse
// on the following cycle, with out_ch/out_data/out_sat valid only while
// out_valid is high.
module wave_diff_lag #(
    parameter int W        = 8,
    parameter int CHANNELS = 2,
    parameter int CH_W     = 1,
    parameter int LAG_MAX  = 8,
    parameter int LAG_W    = 4,
    parameter bit NEGATE   = 1'b1,
    parameter int GAIN_SHL = 0
) (
    input  logic             clk_50M,
    input  logic             rst,
    input  logic             clear,
    input  logic [LAG_W-1:0] lag,
    input  logic             offset_mode,
    input  logic             in_valid,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    output logic [CH_W-1:0]  out_ch,
    output logic [W-1:0]     out_data,
    output logic             out_sat,
    output logic             err_ch,
    output logic [15:0]      out_cnt
);

    import wave_diff_pkg::*;

    localparam int SW = W + GAIN_SHL + 1;

    logic                 bad_ch;
    logic                 accept;
    logic [LAG_W-1:0]     lag_n;
    logic [W-1:0]         hist_data;
    logic                 hist_ready;
    logic signed [W:0]    diff;
    logic signed [SW-1:0] scaled;
    clamp_t               clamped;
    logic [W-1:0]         y_twos;
    logic [W-1:0]         y_out;
    logic                 unused_clamp_bits;

    // Classify the incoming strobe and normalise the lag for this sample.
    always_comb begin
        bad_ch = (32'(in_ch) >= 32'(CHANNELS));
        accept = in_valid && !clear && !bad_ch;
        lag_n  = LAG_W'(norm_lag(int'(lag), LAG_MAX));
    end

    wave_hist_ring #(
        .W        (W),
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W),
        .LAG_MAX  (LAG_MAX),
        .LAG_W    (LAG_W)
    ) u_ring (
        .clk_50M  (clk_50M),
        .rst      (rst),
        .clear    (clear),
        .wr_en    (accept),
        .wr_ch    (in_ch),
        .wr_data  (in_data),
        .rd_ch    (in_ch),
        .rd_lag   (lag_n),
        .rd_data  (hist_data),
        .rd_ready (hist_ready)
    );

    // Difference, gain shift at full width, clamp, then optional MSB flip.
    always_comb begin
        if (NEGATE) begin
            diff = $signed({1'b0, hist_data}) - $signed({1'b0, in_data});
        end else begin
            diff = $signed({1'b0, in_data}) - $signed({1'b0, hist_data});
        end
        scaled  = $signed(SW'(diff));
        scaled  = scaled <<< GAIN_SHL;
        clamped = sat_clamp(64'(scaled), W);
        y_twos  = clamped.val[W-1:0];
        if (offset_mode == OUT_OFFSET) begin
            y_out = {~y_twos[W-1], y_twos[W-2:0]};
        end else begin
            y_out = y_twos;
        end
        unused_clamp_bits = ^clamped.val[63:W];
    end

    // Register results, the bad-channel pulse and the output counter.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            err_ch    <= 1'b0;
            out_cnt   <= '0;
        end else begin
            out_valid <= 1'b0;
            err_ch    <= 1'b0;
            if (clear) begin
                out_cnt <= '0;
            end else if (in_valid && bad_ch) begin
                err_ch <= 1'b1;
            end else if (accept && hist_ready) begin
                out_valid <= 1'b1;
                out_ch    <= in_ch;
                out_data  <= y_out;
                out_sat   <= clamped.sat;
                out_cnt   <= out_cnt + 16'd1;
            end
        end
    end

endmodule
